traffic_req_arbiter: RTL and testbench
======================================

# traffic_req_arbiter

Upstream request stage for the traffic light controller. It synchronises and debounces three raw sensor inputs (main-road loop, side-road loop, pedestrian button), latches each debounced rising edge as a pending request, and arbitrates the pending requests into the 2-bit phase request code and enable that the controller consumes. Each granted code is held for a minimum time, followed by a one-cycle idle gap, so the controller sees clean, well-separated requests.

## Interface
- `DEBOUNCE_CYC`, 4: consecutive stable synchronised samples required to accept a level change (≥2).
- `HOLD_CYC`, 8: cycles a granted request code is held on `req_code` (≥1).
- `clk` input 1: single clock; all logic on rising edge.
- `res` input 1: synchronous, active-high reset.
- `sensor_main` input 1: raw main-road detector, asynchronous.
- `sensor_side` input 1: raw side-road detector, asynchronous.
- `ped_btn` input 1: raw pedestrian button, asynchronous.
- `en_in` input 1: arbiter enable from the supervisor.
- `req_code` output 2: 2'b00 = main phase, 2'b01 = side phase, 2'b10 = pedestrian phase, 2'b11 = idle (no request; the controller free-runs).
- `req_en` output 1: registered copy of `en_in`; drives the controller's enable.
- `pend` output 3: pending bits {ped, side, main}, for status and debug.

## Operation
- Reset: `req_code`=2'b11, `req_en`=0, `pend`=3'b000, debounced levels=0, all counters=0, FSM=IDLE, round-robin pointer=main.
- Synchroniser: two flops per raw input.
- Debounce, per input:
  - Synchronised sample ≠ debounced level: counter increments.
  - Counter reaches `DEBOUNCE_CYC`-1 while still differing: debounced level takes the sample; counter clears.
  - Sample = debounced level: counter clears.
  - Result: pulses shorter than `DEBOUNCE_CYC` samples are rejected.
- Edge latch: a debounced 0→1 transition sets the corresponding `pend` bit. Falling edges are ignored.
- Arbitration: fixed priority ped > side > main.
- FSM states:
  - IDLE: `req_code`=11. If `en_in`=1 and `pend`≠0, grant the winner: clear its `pend` bit, load the hold counter, go to ISSUE.
  - ISSUE: `req_code`=granted code. Hold counter counts `HOLD_CYC` cycles, then go to GAP.
  - GAP: `req_code`=11 for exactly one cycle, then go to IDLE.
- Set/clear collision: if a new edge for a source arrives in the same cycle its bit is cleared by a grant, set wins and the bit stays pending.
- Edge during ISSUE of the same source: sets `pend` again; the source is served after the current grant.
- `en_in`=0 in any state:
  - Next cycle: FSM=IDLE, `req_code`=11.
  - An aborted ISSUE restores the granted source's `pend` bit.
  - Debouncers and edge latching keep running.
- `res` mid-operation: everything returns to reset values on the next edge; pending requests are discarded.
- Hold counter width: $clog2(`HOLD_CYC`+1). Debounce counter width: $clog2(`DEBOUNCE_CYC`+1). Neither counter ever wraps.

## Timing
- Raw input rising, sampled at edge k: synchronised at k+2; debounced level rises at k+1+`DEBOUNCE_CYC`; `pend` set at k+2+`DEBOUNCE_CYC`.
- Grant from IDLE: `req_code` valid one edge after `pend` is set. This gives k+3+`DEBOUNCE_CYC` (k+7 with defaults).
- Each grant occupies `HOLD_CYC`+1 cycles of code plus gap, then IDLE. The next grant is issued from IDLE one cycle later, so back-to-back grants are spaced `HOLD_CYC`+2 cycles apart.
- `req_en` follows `en_in` with exactly one cycle of latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `TRAFFIC_REQ_RR_EN`.
- Defined: round-robin arbitration. The pointer holds the last granted source; the search order starts at the next source in main→side→ped→main order. The pointer updates on every grant and resets to main, so the first search starts at side.
- Undefined: fixed priority ped > side > main; no pointer logic is present.

## Test plan
Defaults `DEBOUNCE_CYC`=4, `HOLD_CYC`=8.
- Reset: `res`=1 for 2 cycles with all sensors high → `req_code`=11, `req_en`=0, `pend`=000 throughout reset and on the first cycle after.
- Single request: `en_in`=1, then `sensor_main` rises and stays high → `pend`[0] sets at k+6; `req_code`=00 for cycles k+7..k+14, 11 at k+15, `pend`=000 thereafter.
- Glitch rejection: `ped_btn` high for 3 cycles → `pend` stays 000 and `req_code` stays 11.
- Collision: side and ped pending simultaneously, macro undefined → `req_code` 10 ×8, 11 ×2, 01 ×8, 11.
- Abort: `en_in` dropped in the 4th cycle of a side grant → `req_code`=11 next cycle and `pend`[1] restored; on `en_in` re-raise, `req_code`=01 for a full 8 cycles.
- Round-robin (`TRAFFIC_REQ_RR_EN` defined): all three sources re-pending continuously → grant order side, ped, main, side, ….

Source files
------------

// File: rtl/traffic_req_arbiter.sv
// Sensor synchroniser, debouncer, edge latch and phase-request arbiter for the traffic controller.
// Optional TRAFFIC_REQ_RR_EN selects round-robin arbitration instead of fixed ped > side > main.
module traffic_req_arbiter #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned HOLD_CYC     = 8
) (
  input  logic       clk,
  input  logic       res,
  input  logic       sensor_main,
  input  logic       sensor_side,
  input  logic       ped_btn,
  input  logic       en_in,
  output logic [1:0] req_code,
  output logic       req_en,
  output logic [2:0] pend
);

  localparam int unsigned DCW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HCW = $clog2(HOLD_CYC + 1);
  localparam logic [1:0]  CODE_IDLE = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

  // Source index doubles as the request code: 0 main, 1 side, 2 ped.
  logic [2:0]          raw;
  logic [2:0]          sync1_q, sync2_q;
  logic [2:0]          deb_q, deb_d, deb_prev_q;
  logic [2:0][DCW-1:0] cnt_q, cnt_d;
  logic [2:0]          rise;
  logic [2:0]          pend_q, pend_d;
  state_e              state_q, state_d;
  logic [1:0]          code_q, code_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [HCW-1:0]      hold_q, hold_d;
  logic                req_en_q;
  logic [1:0]          win;
  logic                grant;

  assign raw  = {ped_btn, sensor_side, sensor_main};
  assign rise = deb_q & ~deb_prev_q;

  // Debounce: accept a new level only after DEBOUNCE_CYC consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DCW'(DEBOUNCE_CYC - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DCW'(1);
        end
      end
    end
  end

`ifdef TRAFFIC_REQ_RR_EN
  logic [1:0] ptr_q;
  logic [1:0] c0, c1;

  assign c0 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
  assign c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;

  // Search starts just after the last granted source.
  always_comb begin
    win = ptr_q;
    if (pend_q[c0]) begin
      win = c0;
    end else if (pend_q[c1]) begin
      win = c1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      ptr_q <= 2'd0;
    end else if (grant) begin
      ptr_q <= win;
    end
  end
`else
  always_comb begin
    win = 2'd0;
    if (pend_q[2]) begin
      win = 2'd2;
    end else if (pend_q[1]) begin
      win = 2'd1;
    end
  end
`endif

  // Next-state and registered-output logic; a new edge always wins over a clear.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    grant   = 1'b0;
    if (!en_in) begin
      state_d = IDLE;
      code_d  = CODE_IDLE;
      hold_d  = '0;
      if (state_q == ISSUE) begin
        pend_d[gnt_q] = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          code_d = CODE_IDLE;
          if (|pend_q) begin
            grant       = 1'b1;
            gnt_d       = win;
            code_d      = win;
            pend_d[win] = 1'b0;
            hold_d      = HCW'(HOLD_CYC - 1);
            state_d     = ISSUE;
          end
        end
        ISSUE: begin
          if (hold_q == '0) begin
            state_d = GAP;
            code_d  = CODE_IDLE;
          end else begin
            hold_d = hold_q - HCW'(1);
          end
        end
        GAP: begin
          state_d = IDLE;
          code_d  = CODE_IDLE;
        end
        default: begin
          state_d = IDLE;
          code_d  = CODE_IDLE;
        end
      endcase
    end
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      state_q    <= IDLE;
      code_q     <= CODE_IDLE;
      gnt_q      <= 2'd0;
      hold_q     <= '0;
      req_en_q   <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      code_q     <= code_d;
      gnt_q      <= gnt_d;
      hold_q     <= hold_d;
      req_en_q   <= en_in;
    end
  end

  assign req_code = code_q;
  assign req_en   = req_en_q;
  assign pend     = pend_q;

endmodule

// File: tb/tb_traffic_req_arbiter.sv
// Directed bench for traffic_req_arbiter with default parameters and fixed-priority arbitration.
module tb_traffic_req_arbiter;

  logic       clk = 1'b0;
  logic       res;
  logic       sensor_main, sensor_side, ped_btn, en_in;
  logic [1:0] req_code;
  logic       req_en;
  logic [2:0] pend;

  int checks   = 0;
  int failures = 0;

  traffic_req_arbiter #(.DEBOUNCE_CYC(4), .HOLD_CYC(8)) dut (
    .clk         (clk),
    .res         (res),
    .sensor_main (sensor_main),
    .sensor_side (sensor_side),
    .ped_btn     (ped_btn),
    .en_in       (en_in),
    .req_code    (req_code),
    .req_en      (req_en),
    .pend        (pend)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cyc, input logic [1:0] code_e,
                         input logic [2:0] pend_e, input logic en_e);
    chk({tag, "_code"}, cyc, {1'b0, req_code}, {1'b0, code_e});
    chk({tag, "_pend"}, cyc, pend, pend_e);
    chk({tag, "_en"},   cyc, {2'b00, req_en}, {2'b00, en_e});
  endtask

  initial begin
    // Reset with every sensor asserted.
    res = 1'b1; sensor_main = 1'b1; sensor_side = 1'b1; ped_btn = 1'b1; en_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all("reset", i, 2'b11, 3'b000, 1'b0);
    end
    res = 1'b0; sensor_main = 1'b0; sensor_side = 1'b0; ped_btn = 1'b0;
    tick();
    chk_all("post_reset", 0, 2'b11, 3'b000, 1'b0);

    en_in = 1'b1;
    tick();
    chk_all("en_latency", 0, 2'b11, 3'b000, 1'b1);

    // Single main request: pend at k+6, code 00 for k+7..k+14.
    sensor_main = 1'b1;
    for (int j = 0; j <= 18; j++) begin
      tick();
      chk_all("single", j, (j >= 7 && j <= 14) ? 2'b00 : 2'b11,
              (j == 6) ? 3'b001 : 3'b000, 1'b1);
    end
    sensor_main = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk_all("main_fall", j, 2'b11, 3'b000, 1'b1);
    end

    // Three-cycle pedestrian glitch is rejected.
    ped_btn = 1'b1;
    tick(); tick(); tick();
    ped_btn = 1'b0;
    for (int j = 3; j < 15; j++) begin
      tick();
      chk_all("glitch", j, 2'b11, 3'b000, 1'b1);
    end

    // Side and ped together: ped first, gap of two, then side.
    sensor_side = 1'b1; ped_btn = 1'b1;
    for (int j = 0; j <= 26; j++) begin
      logic [1:0] ce;
      logic [2:0] pe;
      tick();
      ce = 2'b11;
      if (j >= 7 && j <= 14) ce = 2'b10;
      if (j >= 17 && j <= 24) ce = 2'b01;
      pe = 3'b000;
      if (j == 6) pe = 3'b110;
      if (j >= 7 && j <= 16) pe = 3'b010;
      chk_all("collide", j, ce, pe, 1'b1);
    end
    sensor_side = 1'b0; ped_btn = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    chk_all("collide_idle", 0, 2'b11, 3'b000, 1'b1);

    // Abort a side grant in its 4th cycle, then re-enable.
    sensor_side = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      tick();
      chk_all("abort_pre", j, (j >= 7) ? 2'b01 : 2'b11, (j == 6) ? 3'b010 : 3'b000, 1'b1);
    end
    en_in = 1'b0;
    tick();
    chk_all("abort", 11, 2'b11, 3'b010, 1'b0);
    tick();
    chk_all("abort", 12, 2'b11, 3'b010, 1'b0);
    en_in = 1'b1;
    for (int j = 13; j <= 22; j++) begin
      tick();
      chk_all("regrant", j, (j <= 20) ? 2'b01 : 2'b11, 3'b000, 1'b1);
    end
    sensor_side = 1'b0;
    for (int j = 0; j < 10; j++) tick();

    // Reset during an active grant discards everything.
    sensor_main = 1'b1;
    for (int j = 0; j <= 9; j++) tick();
    chk_all("mid_issue", 9, 2'b00, 3'b000, 1'b1);
    res = 1'b1; sensor_main = 1'b0;
    tick();
    chk_all("mid_reset", 0, 2'b11, 3'b000, 1'b0);
    res = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk_all("after_reset", j, 2'b11, 3'b000, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
